// File: rtl/arm7tdmi_exception_entry_pkg.sv
// Shared types for exception entry: exception kinds, processor modes,
// entry sequencer states and the return-address (LR) offset rule.
package arm7tdmi_exception_entry_pkg;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B,
        MODE_SYS = 5'h1F
    } processor_mode_t;

    typedef enum logic [2:0] {
        EXC_RESET = 3'd0,
        EXC_UNDEF = 3'd1,
        EXC_SWI   = 3'd2,
        EXC_PABT  = 3'd3,
        EXC_DABT  = 3'd4,
        EXC_IRQ   = 3'd5,
        EXC_FIQ   = 3'd6,
        EXC_RSVD  = 3'd7
    } exc_type_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_SPSR = 3'd1,
        ST_WR_LR   = 3'd2,
        ST_WR_CPSR = 3'd3,
        ST_LOAD_PC = 3'd4,
        ST_REFILL  = 3'd5
    } entry_state_t;

    localparam logic [31:0] LR_OFS_NONE  = 32'd0;
    localparam logic [31:0] LR_OFS_THUMB = 32'd2;
    localparam logic [31:0] LR_OFS_ARM   = 32'd4;
    localparam logic [31:0] LR_OFS_DABT  = 32'd8;

    localparam logic [3:0] LR_REG_INDEX = 4'd14;

    // Only UNDEF and SWI depend on the instruction set; the reserved
    // encoding is treated as a fixed +4 regardless of Thumb state.
    function automatic logic [31:0] lr_offset(input exc_type_t t, input logic thumb);
        logic [31:0] ofs;
        ofs = LR_OFS_NONE;
        case (t)
            EXC_UNDEF, EXC_SWI: ofs = thumb ? LR_OFS_THUMB : LR_OFS_ARM;
            EXC_PABT:           ofs = LR_OFS_ARM;
            EXC_DABT:           ofs = LR_OFS_DABT;
            EXC_IRQ, EXC_FIQ:   ofs = LR_OFS_ARM;
            EXC_RSVD:           ofs = LR_OFS_ARM;
            default:            ofs = LR_OFS_NONE;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/arm7tdmi_exception_entry.sv
// Sequences architectural exception entry: SPSR, LR and CPSR writes, then
// PC redirect with pipeline flush and a fixed refill stall window.
module arm7tdmi_exception_entry
    import arm7tdmi_exception_entry_pkg::*;
#(
    parameter int REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_taken,
    input  logic [2:0]  exception_type,
    input  logic [4:0]  exception_mode,
    input  logic [31:0] exception_vector,
    input  logic [31:0] exception_cpsr,
    input  logic [31:0] exception_spsr,
    input  logic [31:0] current_pc,
    input  logic        thumb,
    output logic        exception_ack,
    output logic        entry_busy,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_mode,
    output logic [3:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        spsr_wr_en,
    output logic [4:0]  spsr_wr_mode,
    output logic [31:0] spsr_wr_data,
    output logic        cpsr_wr_en,
    output logic [31:0] cpsr_wr_data,
    output logic        pc_load_en,
    output logic [31:0] pc_load_addr,
    output logic        pipeline_flush,
    output logic        entry_done
);

    localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES - 1);

    entry_state_t state_q;
    entry_state_t state_d;
    exc_type_t    type_in;

    logic [4:0]  mode_q;
    logic [31:0] vector_q;
    logic [31:0] cpsr_q;
    logic [31:0] spsr_q;
    logic [31:0] lr_q;
    logic [3:0]  cnt_q;

    assign type_in = exc_type_t'(exception_type);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (exception_taken)
                    state_d = (type_in == EXC_RESET) ? ST_WR_CPSR : ST_WR_SPSR;
            end
            ST_WR_SPSR: state_d = ST_WR_LR;
            ST_WR_LR:   state_d = ST_WR_CPSR;
            ST_WR_CPSR: state_d = ST_LOAD_PC;
            ST_LOAD_PC: state_d = ST_REFILL;
            ST_REFILL: begin
                if (cnt_q == 4'd0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            vector_q <= '0;
            cpsr_q   <= '0;
            spsr_q   <= '0;
            lr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && exception_taken) begin
                mode_q   <= exception_mode;
                vector_q <= exception_vector;
                cpsr_q   <= exception_cpsr;
                spsr_q   <= exception_spsr;
                lr_q     <= current_pc + lr_offset(type_in, thumb);
            end
            if (state_q == ST_LOAD_PC)
                cnt_q <= REFILL_LOAD;
            else if (state_q == ST_REFILL && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
        end
    end

    // All outputs decode from registered state; only the ack sees the input.
    always_comb begin
        exception_ack  = 1'b0;
        entry_busy     = 1'b1;
        rf_wr_en       = 1'b0;
        rf_wr_mode     = '0;
        rf_wr_addr     = '0;
        rf_wr_data     = '0;
        spsr_wr_en     = 1'b0;
        spsr_wr_mode   = '0;
        spsr_wr_data   = '0;
        cpsr_wr_en     = 1'b0;
        cpsr_wr_data   = '0;
        pc_load_en     = 1'b0;
        pc_load_addr   = '0;
        pipeline_flush = 1'b0;
        entry_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                entry_busy    = 1'b0;
                exception_ack = exception_taken;
            end
            ST_WR_SPSR: begin
                spsr_wr_en   = 1'b1;
                spsr_wr_mode = mode_q;
                spsr_wr_data = spsr_q;
            end
            ST_WR_LR: begin
                rf_wr_en   = 1'b1;
                rf_wr_mode = mode_q;
                rf_wr_addr = LR_REG_INDEX;
                rf_wr_data = lr_q;
            end
            ST_WR_CPSR: begin
                cpsr_wr_en   = 1'b1;
                cpsr_wr_data = cpsr_q;
            end
            ST_LOAD_PC: begin
                pc_load_en     = 1'b1;
                pc_load_addr   = vector_q;
                pipeline_flush = 1'b1;
            end
            ST_REFILL: begin
                entry_done = (cnt_q == 4'd0);
            end
            default: begin
                entry_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arm7tdmi_exception_entry.sv
// Directed bench for arm7tdmi_exception_entry with hand-computed LR values
// and a per-cycle expected strobe pattern.
module tb_arm7tdmi_exception_entry;

    localparam int R = 2;

    logic        clk;
    logic        rst;
    logic        exception_taken;
    logic [2:0]  exception_type;
    logic [4:0]  exception_mode;
    logic [31:0] exception_vector;
    logic [31:0] exception_cpsr;
    logic [31:0] exception_spsr;
    logic [31:0] current_pc;
    logic        thumb;
    logic        exception_ack;
    logic        entry_busy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_mode;
    logic [3:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        spsr_wr_en;
    logic [4:0]  spsr_wr_mode;
    logic [31:0] spsr_wr_data;
    logic        cpsr_wr_en;
    logic [31:0] cpsr_wr_data;
    logic        pc_load_en;
    logic [31:0] pc_load_addr;
    logic        pipeline_flush;
    logic        entry_done;

    int checks = 0;
    int errors = 0;

    // request presented while the current entry is busy (back-to-back case)
    logic [2:0]  nxt_type;
    logic [4:0]  nxt_mode;
    logic [31:0] nxt_vec, nxt_cpsr, nxt_spsr, nxt_pc;
    logic        nxt_thumb;

    arm7tdmi_exception_entry #(.REFILL_CYCLES(R)) dut (
        .clk              (clk),
        .rst              (rst),
        .exception_taken  (exception_taken),
        .exception_type   (exception_type),
        .exception_mode   (exception_mode),
        .exception_vector (exception_vector),
        .exception_cpsr   (exception_cpsr),
        .exception_spsr   (exception_spsr),
        .current_pc       (current_pc),
        .thumb            (thumb),
        .exception_ack    (exception_ack),
        .entry_busy       (entry_busy),
        .rf_wr_en         (rf_wr_en),
        .rf_wr_mode       (rf_wr_mode),
        .rf_wr_addr       (rf_wr_addr),
        .rf_wr_data       (rf_wr_data),
        .spsr_wr_en       (spsr_wr_en),
        .spsr_wr_mode     (spsr_wr_mode),
        .spsr_wr_data     (spsr_wr_data),
        .cpsr_wr_en       (cpsr_wr_en),
        .cpsr_wr_data     (cpsr_wr_data),
        .pc_load_en       (pc_load_en),
        .pc_load_addr     (pc_load_addr),
        .pipeline_flush   (pipeline_flush),
        .entry_done       (entry_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {spsr,rf,cpsr,pc,flush,done,busy,ack} for cycle c after the ack.
    function automatic logic [7:0] exp_strobes(input int c, input bit is_rst, input bit hold);
        int k;
        k = is_rst ? c + 2 : c;
        if (k == 1)           return 8'b1000_0010;
        else if (k == 2)      return 8'b0100_0010;
        else if (k == 3)      return 8'b0010_0010;
        else if (k == 4)      return 8'b0001_1010;
        else if (k < 4 + R)   return 8'b0000_0010;
        else if (k == 4 + R)  return 8'b0000_0110;
        else                  return {7'b0, hold};
    endfunction

    function automatic logic [7:0] obs_strobes();
        return {spsr_wr_en, rf_wr_en, cpsr_wr_en, pc_load_en, pipeline_flush,
                entry_done, entry_busy, exception_ack};
    endfunction

    function automatic logic [141:0] obs_data();
        return {spsr_wr_mode, spsr_wr_data, rf_wr_mode, rf_wr_addr, rf_wr_data,
                cpsr_wr_data, pc_load_addr};
    endfunction

    // Presents one request in an IDLE cycle and checks every cycle until IDLE.
    task automatic walk_entry(input string nm, input logic [2:0] ty, input logic [4:0] md,
                              input logic [31:0] pc, input logic th, input logic [31:0] vec,
                              input logic [31:0] cpsr, input logic [31:0] spsr,
                              input logic [31:0] exp_lr, input bit hold);
        bit is_rst;
        int last;
        logic [7:0] es;
        logic [141:0] ed;
        is_rst = (ty == 3'd0);
        last = is_rst ? 3 + R : 5 + R;
        exception_taken  = 1'b1;
        exception_type   = ty;
        exception_mode   = md;
        current_pc       = pc;
        thumb            = th;
        exception_vector = vec;
        exception_cpsr   = cpsr;
        exception_spsr   = spsr;
        #1;
        checks++;
        if (exception_ack !== 1'b1 || entry_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s c0 ack/busy: got %b%b want 10", nm, exception_ack, entry_busy);
        end
        @(posedge clk);
        #1;
        if (hold) begin
            exception_type   = nxt_type;
            exception_mode   = nxt_mode;
            current_pc       = nxt_pc;
            thumb            = nxt_thumb;
            exception_vector = nxt_vec;
            exception_cpsr   = nxt_cpsr;
            exception_spsr   = nxt_spsr;
        end else begin
            exception_taken = 1'b0;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            es = exp_strobes(c, is_rst, hold);
            ed = {es[7] ? md : 5'd0, es[7] ? spsr : 32'd0,
                  es[6] ? md : 5'd0, es[6] ? 4'd14 : 4'd0, es[6] ? exp_lr : 32'd0,
                  es[5] ? cpsr : 32'd0, es[4] ? vec : 32'd0};
            checks++;
            if (obs_strobes() !== es) begin
                errors++;
                $display("FAIL %s c%0d strobes: got %b want %b", nm, c, obs_strobes(), es);
            end
            checks++;
            if (obs_data() !== ed) begin
                errors++;
                $display("FAIL %s c%0d data: got %h want %h", nm, c, obs_data(), ed);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exception_taken = 1'b0;
        exception_type = '0;
        exception_mode = '0;
        exception_vector = '0;
        exception_cpsr = '0;
        exception_spsr = '0;
        current_pc = '0;
        thumb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_strobes() !== 8'b0 || obs_data() !== 142'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b/%h want 0/0", obs_strobes(), obs_data());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (entry_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle busy: got %b want 0", entry_busy);
        end
    endtask

    task automatic test_dabt();
        walk_entry("dabt", 3'd4, 5'h17, 32'h0000_1000, 1'b0, 32'h10,
                   32'h0000_00D7, 32'h6000_001F, 32'h0000_1008, 1'b0);
    endtask

    task automatic test_swi();
        walk_entry("swi_thumb", 3'd2, 5'h13, 32'h0000_2000, 1'b1, 32'h08,
                   32'h0000_00D3, 32'h0000_003F, 32'h0000_2002, 1'b0);
        walk_entry("swi_arm", 3'd2, 5'h13, 32'h0000_2000, 1'b0, 32'h08,
                   32'h0000_00D3, 32'h0000_001F, 32'h0000_2004, 1'b0);
    endtask

    task automatic test_other_types();
        walk_entry("pabt_thumb", 3'd3, 5'h17, 32'h0000_0500, 1'b1, 32'h0C,
                   32'h0000_0097, 32'h0000_0030, 32'h0000_0504, 1'b0);
        walk_entry("undef_thumb", 3'd1, 5'h1B, 32'h0000_0600, 1'b1, 32'h04,
                   32'h0000_009B, 32'h0000_0030, 32'h0000_0602, 1'b0);
        walk_entry("reserved", 3'd7, 5'h1B, 32'h0000_0100, 1'b1, 32'h04,
                   32'h0000_009B, 32'h0000_0030, 32'h0000_0104, 1'b0);
    endtask

    task automatic test_reset_type();
        walk_entry("reset_type", 3'd0, 5'h13, 32'h0000_4444, 1'b0, 32'h0,
                   32'h0000_00D3, 32'h1234_5678, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        walk_entry("lr_wrap", 3'd4, 5'h17, 32'hFFFF_FFFC, 1'b0, 32'h10,
                   32'h0000_00D7, 32'h0000_0010, 32'h0000_0004, 1'b0);
    endtask

    task automatic test_back_to_back();
        nxt_type  = 3'd5;
        nxt_mode  = 5'h12;
        nxt_pc    = 32'h0000_4000;
        nxt_thumb = 1'b0;
        nxt_vec   = 32'h18;
        nxt_cpsr  = 32'h0000_0092;
        nxt_spsr  = 32'h0000_001F;
        walk_entry("fiq_busy", 3'd6, 5'h11, 32'h0000_3000, 1'b0, 32'h1C,
                   32'h0000_00D1, 32'h0000_0010, 32'h0000_3004, 1'b1);
        walk_entry("irq_after", 3'd5, 5'h12, 32'h0000_4000, 1'b0, 32'h18,
                   32'h0000_0092, 32'h0000_001F, 32'h0000_4004, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic late;
        late = 1'b0;
        exception_taken  = 1'b1;
        exception_type   = 3'd4;
        exception_mode   = 5'h17;
        current_pc       = 32'h0000_1000;
        thumb            = 1'b0;
        exception_vector = 32'h10;
        exception_cpsr   = 32'h0000_00D7;
        exception_spsr   = 32'h6000_001F;
        @(posedge clk);
        #1;
        exception_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rf_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in WR_LR: rf_wr_en got %b want 1", rf_wr_en);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_strobes() !== 8'b0 || obs_data() !== 142'b0) begin
            errors++;
            $display("FAIL rst_mid abort: got %b/%h want 0/0", obs_strobes(), obs_data());
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            late = late | cpsr_wr_en | pc_load_en | entry_busy;
        end
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid late strobes: got %b want 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_dabt();
        test_swi();
        test_other_types();
        test_reset_type();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arm7tdmi_exception_entry.md
Name: arm7tdmi_exception_entry

Overview:
- Downstream consumer of arm7tdmi_exception; sequences architectural exception entry once an exception is taken.
- Captures the exception decision (type, mode, vector, new CPSR, saved SPSR, PC) and issues ordered single-cycle writes to the banked register file: SPSR_<mode>, LR_<mode>, CPSR.
- Then loads the PC with the vector, flushes the pipeline, and holds the core stalled for a fixed refill window.

Parameters:
- REFILL_CYCLES, 2, cycles held in REFILL after PC load; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- exception_taken  in  1  exception decision valid this cycle (level; upstream re-asserts until acked)
- exception_type  in  3  exc_type_t: 0 RESET, 1 UNDEF, 2 SWI, 3 PABT, 4 DABT, 5 IRQ, 6 FIQ; 7 reserved
- exception_mode  in  5  processor_mode_t target mode
- exception_vector  in  32  handler address
- exception_cpsr  in  32  CPSR value to install
- exception_spsr  in  32  CPSR value to save into SPSR_<mode>
- current_pc  in  32  address of instruction in execute
- thumb  in  1  CPSR.T at exception time
- exception_ack  out  1  request captured this cycle
- entry_busy  out  1  stall core/fetch
- rf_wr_en  out  1  banked GPR write strobe
- rf_wr_mode  out  5  bank selector
- rf_wr_addr  out  4  register index (always 14)
- rf_wr_data  out  32  LR value
- spsr_wr_en  out  1  SPSR write strobe
- spsr_wr_mode  out  5  SPSR bank selector
- spsr_wr_data  out  32  saved PSR
- cpsr_wr_en  out  1  CPSR write strobe
- cpsr_wr_data  out  32  new CPSR
- pc_load_en  out  1  PC redirect strobe
- pc_load_addr  out  32  redirect target
- pipeline_flush  out  1  kill fetch/decode contents
- entry_done  out  1  one-cycle pulse, entry complete

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; all strobes, entry_busy, exception_ack and entry_done are 0.
  - Captured registers, data and address outputs are 0.
  - Reset mid-sequence aborts the sequence immediately; no further strobes are issued.
- IDLE:
  - exception_ack = exception_taken, combinationally; this is the only input-to-output path.
  - On exception_taken=1 at the clk edge, capture all inputs.
  - Compute LR = current_pc + offset, modulo 2^32 (wraps, no saturation).
  - LR offsets: UNDEF/SWI +4 in ARM, +2 in Thumb; PABT +4; DABT +8; IRQ/FIQ +4.
  - Next state: RESET type goes to WR_CPSR; every other type goes to WR_SPSR.
- WR_SPSR, 1 cycle: spsr_wr_en=1, spsr_wr_mode=captured mode, spsr_wr_data=captured spsr. Next state WR_LR.
- WR_LR, 1 cycle: rf_wr_en=1, rf_wr_addr=14, rf_wr_mode=captured mode, rf_wr_data=LR. Next state WR_CPSR.
- WR_CPSR, 1 cycle: cpsr_wr_en=1, cpsr_wr_data=captured cpsr. Next state LOAD_PC.
- LOAD_PC, 1 cycle: pc_load_en=1, pc_load_addr=captured vector, pipeline_flush=1. Load refill counter with REFILL_CYCLES-1. Next state REFILL.
- REFILL:
  - The counter decrements each cycle.
  - When the counter reaches 0, entry_done=1 for that cycle and the next state is IDLE.
- Timing:
  - entry_busy=1 in every state except IDLE, including the entry_done cycle.
  - Non-reset exception, ack in cycle 0: SPSR write in cycle 1, LR in 2, CPSR in 3, PC load in 4, entry_done in 4+REFILL_CYCLES.
  - RESET type: CPSR write in cycle 1, PC load in 2, entry_done in 2+REFILL_CYCLES.
- Strobes are mutually exclusive per cycle. Data and address outputs are driven 0 when their strobe is low.
- exception_taken is ignored while not in IDLE (exception_ack=0). A request held through the entry_done cycle is accepted in the first IDLE cycle after it, so back-to-back entries have a 1-cycle IDLE gap.
- exception_type=7 is captured and sequenced like UNDEF with LR offset +4, with no error signalled.

Decomposition:
- arm7tdmi_pkg additions:
  - exc_type_t enum (values above).
  - entry_state_t enum: IDLE, WR_SPSR, WR_LR, WR_CPSR, LOAD_PC, REFILL.
  - LR offset constants.
  - Function lr_offset(exc_type_t, thumb) returning 32-bit.
- Reuse the existing processor_mode_t.
- No sub-module; a single FSM plus capture registers and a 4-bit counter.

Test Plan:
- DABT, mode ABORT (0x17), current_pc=0x00001000, vector 0x10, spsr=0x6000001F -> cycle 1 SPSR_abt=0x6000001F; cycle 2 LR_abt (r14)=0x00001008; cycle 3 CPSR write; cycle 4 pc_load 0x00000010 with flush; entry_done in cycle 6 (REFILL_CYCLES=2).
- SWI with thumb=1, current_pc=0x00002000, mode SVC (0x13) -> LR=0x00002002, vector 0x08. SWI with thumb=0 -> LR=0x00002004.
- RESET type, vector 0x0 -> no spsr_wr_en or rf_wr_en pulses; CPSR write in cycle 1, pc_load in cycle 2, entry_done in cycle 4.
- DABT with current_pc=0xFFFFFFFC -> LR wraps to 0x00000004.
- IRQ held high through a busy FIQ entry -> exception_ack=0 while busy; IRQ acked in the first IDLE cycle after the entry_done cycle; IRQ entry completes with vector 0x18.
- rst asserted in the WR_LR cycle -> next cycle all strobes 0, entry_busy=0, state IDLE; no CPSR write or PC load follows.
